// File: rtl/i2c_pkg.sv
// Shared definitions for the i2c_target_reg8 register-bank I2C target.
//   state_t        : protocol FSM states
//   ACK_BIT/NACK_BIT, RW_WRITE/RW_READ : bus-level bit meanings
package i2c_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 7;

  localparam logic [ADDR_W-1:0] DEV_ADDR_DFLT = 7'h10;

  localparam logic ACK_BIT  = 1'b0;
  localparam logic NACK_BIT = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDAT,
    ST_WDAT_ACK,
    ST_RDAT,
    ST_RD_MACK,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/i2c_target_reg8_if.sv
// Pad and register-bank signals of i2c_target_reg8.
//   slave  modport : the target itself
//   master modport : the bus driver / register bank side
interface i2c_target_reg8_if;
  import i2c_pkg::*;

  logic              SCL_I;
  logic              SDA_I;
  logic              SDA_O;
  logic [BYTE_W-1:0] REG_ADDR;
  logic [BYTE_W-1:0] REG_WDATA;
  logic [BYTE_W-1:0] REG_RDATA;
  logic              REG_WE;
  logic              REG_RE;
  logic              BUSY;

  modport slave (
    input  SCL_I, SDA_I, REG_RDATA,
    output SDA_O, REG_ADDR, REG_WDATA, REG_WE, REG_RE, BUSY
  );

  modport master (
    output SCL_I, SDA_I, REG_RDATA,
    input  SDA_O, REG_ADDR, REG_WDATA, REG_WE, REG_RE, BUSY
  );
endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises the raw SCL/SDA pads and produces one-CLK event pulses.
//   CLK, RESET_N      : system clock, async active-low reset
//   SCL_I, SDA_I      : asynchronous pad inputs
//   sda               : synchronised SDA level
//   scl_rise/scl_fall : SCL edge pulses
//   start/stop        : SDA fall / rise while SCL high
// Pulses appear 3 CLK after the pad edge (2 sync stages + registered event).
module i2c_bus_sync (
  input  logic CLK,
  input  logic RESET_N,
  input  logic SCL_I,
  input  logic SDA_I,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_hist;
  logic       sda_hist;

  // Reset to the idle-bus level so release of reset creates no false events.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      scl_ff   <= 2'b11;
      sda_ff   <= 2'b11;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start    <= 1'b0;
      stop     <= 1'b0;
    end else begin
      scl_ff   <= {scl_ff[0], SCL_I};
      sda_ff   <= {sda_ff[0], SDA_I};
      scl_hist <= scl_ff[1];
      sda_hist <= sda_ff[1];
      scl_rise <= scl_ff[1] & ~scl_hist;
      scl_fall <= ~scl_ff[1] & scl_hist;
      start    <= scl_ff[1] & scl_hist & ~sda_ff[1] & sda_hist;
      stop     <= scl_ff[1] & scl_hist & sda_ff[1] & ~sda_hist;
    end
  end

  assign sda = sda_hist;

endmodule

// File: rtl/i2c_target_reg8.sv
// I2C target bridging SCL/SDA to an 8-bit addressed register bank.
//   CLK, RESET_N : system clock (>= 8x SCL), async active-low reset
//   bus (slave)  : SCL_I/SDA_I/SDA_O pads, REG_ADDR/REG_WDATA/REG_WE,
//                  REG_RE/REG_RDATA, BUSY
// Build option: I2C_TARGET_AUTOINC_EN enables REG_ADDR auto-increment after
// every write strobe and every master-ACKed read byte.
module i2c_target_reg8
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DEV_ADDR = DEV_ADDR_DFLT
) (
  input logic             CLK,
  input logic             RESET_N,
  i2c_target_reg8_if.slave bus
);

  logic sda, scl_rise, scl_fall, start_evt, stop_evt;

  i2c_bus_sync u_sync (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .SCL_I    (bus.SCL_I),
    .SDA_I    (bus.SDA_I),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start_evt),
    .stop     (stop_evt)
  );

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]  shreg_q, shreg_d;
  logic [BYTE_W-1:0]  reg_addr_q, reg_addr_d;
  logic [BYTE_W-1:0]  reg_wdata_q, reg_wdata_d;
  logic               reg_we_q, reg_we_d;
  logic               reg_re_q, reg_re_d;
  logic               sda_o_q, sda_o_d;
  logic               busy_q, busy_d;
  logic               mack_q, mack_d;
  logic               drive_q, drive_d;

  logic              byte_done;
  logic              addr_match;
  logic [BYTE_W-1:0] rx_byte;

  assign byte_done  = (bit_cnt_q == CNT_W'(BYTE_W));
  assign addr_match = (shreg_q[7:1] == DEV_ADDR) && (shreg_q[7:1] != 7'h00);
  assign rx_byte    = {shreg_q[6:0], sda};

  // State and datapath registers; SDA release on reset is asynchronous.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      sda_o_q     <= 1'b1;
      busy_q      <= 1'b0;
      mack_q      <= NACK_BIT;
      drive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      sda_o_q     <= sda_o_d;
      busy_q      <= busy_d;
      mack_q      <= mack_d;
      drive_q     <= drive_d;
    end
  end

  // Next state: START/STOP override everything, otherwise byte/ACK sequencing.
  always_comb begin
    state_d = state_q;
    if (stop_evt) begin
      state_d = ST_IDLE;
    end else if (start_evt) begin
      state_d = ST_ADDR;
    end else begin
      case (state_q)
        ST_ADDR:     if (scl_fall && byte_done) state_d = addr_match ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK: if (scl_fall) state_d = (shreg_q[0] == RW_WRITE) ? ST_PTR : ST_RDAT;
        ST_PTR:      if (scl_fall && byte_done) state_d = ST_PTR_ACK;
        ST_PTR_ACK:  if (scl_fall) state_d = ST_WDAT;
        ST_WDAT:     if (scl_fall && byte_done) state_d = ST_WDAT_ACK;
        ST_WDAT_ACK: if (scl_fall) state_d = ST_WDAT;
        ST_RDAT:     if (scl_fall && byte_done) state_d = ST_RD_MACK;
        ST_RD_MACK:  if (scl_fall) state_d = (mack_q == ACK_BIT) ? ST_RDAT : ST_IGNORE;
        default:     state_d = state_q;
      endcase
    end
  end

  // Outputs and datapath next values.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    sda_o_d     = sda_o_q;
    busy_d      = busy_q;
    mack_d      = mack_q;
    drive_d     = 1'b0;

`ifdef I2C_TARGET_AUTOINC_EN
    if (reg_we_q) reg_addr_d = reg_addr_q + BYTE_W'(1);
`endif

    if (stop_evt) begin
      sda_o_d   = 1'b1;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
    end else if (start_evt) begin
      sda_o_d   = 1'b1;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDAT: begin
          if (scl_rise && !byte_done) begin
            shreg_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(BYTE_W - 1)) begin
              if (state_q == ST_PTR) reg_addr_d = rx_byte;
              if (state_q == ST_WDAT) begin
                reg_wdata_d = rx_byte;
                reg_we_d    = 1'b1;
              end
            end
          end else if (scl_fall && byte_done) begin
            bit_cnt_d = '0;
            if (state_q != ST_ADDR || addr_match) sda_o_d = ACK_BIT;
            if (state_q == ST_ADDR && addr_match) busy_d = 1'b1;
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDAT_ACK: begin
          if (scl_fall) begin
            sda_o_d = 1'b1;
            if (state_q == ST_ADDR_ACK && shreg_q[0] == RW_READ) reg_re_d = 1'b1;
          end
        end
        ST_RDAT: begin
          // Fetch: REG_RE -> load REG_RDATA -> drive MSB, one CLK apart.
          if (reg_re_q) begin
            shreg_d = bus.REG_RDATA;
            drive_d = 1'b1;
          end else if (drive_q) begin
            sda_o_d = shreg_q[7];
          end else if (scl_rise && !byte_done) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else if (scl_fall) begin
            if (byte_done) begin
              sda_o_d   = 1'b1;
              bit_cnt_d = '0;
              mack_d    = NACK_BIT;
            end else if (bit_cnt_q != '0) begin
              sda_o_d = shreg_q[6];
              shreg_d = {shreg_q[6:0], 1'b1};
            end
          end
        end
        ST_RD_MACK: begin
          if (scl_rise) begin
            mack_d = sda;
`ifdef I2C_TARGET_AUTOINC_EN
            if (sda == ACK_BIT) reg_addr_d = reg_addr_q + BYTE_W'(1);
`endif
          end else if (scl_fall && mack_q == ACK_BIT) begin
            reg_re_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.SDA_O     = sda_o_q;
  assign bus.REG_ADDR  = reg_addr_q;
  assign bus.REG_WDATA = reg_wdata_q;
  assign bus.REG_WE    = reg_we_q;
  assign bus.REG_RE    = reg_re_q;
  assign bus.BUSY      = busy_q;

endmodule

// File: doc/i2c_target_reg8.md
# i2c_target_reg8

I2C target (responder) that answers the 3-byte register-write sequence issued by the camera/sensor-side I2C master (slave address, pointer, data) and also serves register reads. Sits between the bidirectional SCL/SDA pads and an 8-bit addressed register bank. It turns bus transfers into single-cycle write/read strobes on the system clock. Used both as a bench model for the master and as an on-chip configuration port.

## Interface
- DEV_ADDR, 7'h10, 7-bit target address matched against the first byte after START.
- CLK  in  1  system clock; must be ≥ 8× SCL frequency.
- RESET_N  in  1  reset, asynchronous, active-low.
- SCL_I  in  1  raw SCL pad input (asynchronous).
- SDA_I  in  1  raw SDA pad input (asynchronous).
- SDA_O  out  1  open-drain control: 0 = pull SDA low, 1 = release.
- REG_ADDR  out  8  current register pointer.
- REG_WDATA  out  8  write data, valid while REG_WE=1.
- REG_WE  out  1  one-CLK write strobe.
- REG_RE  out  1  one-CLK read-fetch strobe.
- REG_RDATA  in  8  read data; must be valid on the CLK after REG_RE.
- BUSY  out  1  high from an address-matched START until STOP.

## Operation
- Front end: 2-FF synchronizer on SCL_I/SDA_I, plus one history register. Events: SCL_RISE, SCL_FALL, START (SDA fall while SCL=1), STOP (SDA rise while SCL=1).
- Data bits sampled on SCL_RISE; SDA_O updated only on SCL_FALL (+1 CLK).
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDAT, WDAT_ACK, RDAT, RD_MACK, IGNORE.
- 4-bit bit counter, 0..8; the 9th clock is the ACK slot.
- START from any state → ADDR, counter cleared. This covers repeated START.
- STOP from any state → IDLE, SDA_O=1, BUSY=0.
- ADDR:
  - Byte[7:1]==DEV_ADDR → ADDR_ACK, drive 0 during ACK.
  - Otherwise → IGNORE, SDA released.
- After ADDR_ACK:
  - R/W=0 → PTR.
  - R/W=1 → RDAT.
- PTR: received byte loads REG_ADDR → PTR_ACK (ACK) → WDAT.
- WDAT: on the 8th SCL_RISE, REG_WDATA = byte and REG_WE pulses 1 CLK with the current REG_ADDR → WDAT_ACK (ACK) → WDAT for further bytes.
- RDAT entry:
  - REG_RE pulses on the SCL_FALL ending the ACK slot.
  - REG_RDATA is loaded into the shift register on the following CLK.
  - MSB is driven on SDA_O on the CLK after that.
- RDAT bits shift out on each SCL_FALL. After 8 bits, SDA is released → RD_MACK.
- RD_MACK, master ACK (SDA=0): → RDAT, new REG_RE.
- RD_MACK, master NACK: → IGNORE until STOP/START.
- General-call address (0x00) is not matched.

## Timing
- Reset values: SDA_O=1, REG_ADDR=0, REG_WDATA=0, REG_WE=0, REG_RE=0, BUSY=0, state IDLE.
- Event detection latency: 3 CLK from pad edge.
- ACK low is asserted 1 CLK after the detected SCL_FALL following bit 8, and released 1 CLK after the next SCL_FALL.
- REG_WE: 1 CLK after the 8th data SCL_RISE is detected.
- Reset mid-transfer: SDA released immediately (async). The rest of the transaction is ignored until a new START.
- STOP during a data byte: partial byte discarded, no REG_WE.

## Configuration
- I2C_TARGET_AUTOINC_EN defined: REG_ADDR increments, wrapping 0xFF→0x00, after every REG_WE and after every master-ACKed read byte.
- Undefined: REG_ADDR changes only on PTR bytes. Consecutive reads return the same register.

## Structure
- Shared package i2c_pkg: state enum, ACK/NACK bit constants, RW_WRITE/RW_READ.
- Sub-module i2c_bus_sync: synchronizers plus SCL_RISE/SCL_FALL/START/STOP pulse generation.

## Test plan
- Write: START, 0x20, 0x3A, 0x5C, STOP with DEV_ADDR=0x10 → three ACKs; one REG_WE with REG_ADDR=0x3A, REG_WDATA=0x5C; BUSY low after STOP.
- Wrong address 0x22 → SDA never driven low; no strobes; BUSY stays 0.
- Read: write pointer 0x07, repeated START, 0x21; REG_RDATA=0xA5 → bits 10100101 on SDA. Master NACK → SDA released.
- Burst: pointer 0xFE, data 0x11, 0x22, 0x33 with AUTOINC → REG_WE at 0xFE, 0xFF, 0x00. Without AUTOINC → all three at 0xFE.
- STOP after 4 data bits → no REG_WE; state IDLE.
- RESET_N pulsed while SDA_O=0 in an ACK slot → SDA_O=1 the same cycle; next START/addr transfer works normally.
